// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, pixel type and framebuffer command types
package vga_pkg;
  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;
  localparam int ADDR_WIDTH = 19;
  typedef logic [7:0] rgb332_t;
  typedef logic [ADDR_WIDTH-1:0] fb_addr_t;
  typedef enum logic {FB_PIXEL, FB_FILL} fb_op_t;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE} fb_state_t;
endpackage

// File: rtl/vga_fb_addr_gen.sv
// vga_fb_addr_gen: raster column/row counters with incremental framebuffer address
module vga_fb_addr_gen #(
  parameter int HW = 10,
  parameter int VW = 10,
  parameter int AW = 19,
  parameter int H = 640
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [HW-1:0] x_start,
  input  logic [VW-1:0] y_start,
  input  logic [HW:0]   x_end,
  input  logic [VW:0]   y_end,
  output logic [AW-1:0] addr,
  output logic          last
);
  logic [HW-1:0] col;
  logic [VW-1:0] row;
  logic [AW-1:0] row_base, base0, next_base;
  logic row_end;
  assign base0 = AW'(y_start) * AW'(H);
  assign next_base = row_base + AW'(H);
  assign row_end = {1'b0, col} + (HW+1)'(1) == x_end;
  assign last = row_end && {1'b0, row} + (VW+1)'(1) == y_end;
  always_ff @(posedge clk)
    if (rst) begin
      col <= '0;
      row <= '0;
      row_base <= '0;
      addr <= '0;
    end else if (load) begin
      col <= x_start;
      row <= y_start;
      row_base <= base0;
      addr <= base0 + AW'(x_start);
    end else if (step) begin
      col <= row_end ? x_start : col + HW'(1);
      row <= row_end ? row + VW'(1) : row;
      row_base <= row_end ? next_base : row_base;
      addr <= row_end ? next_base + AW'(x_start) : addr + AW'(1);
    end
endmodule

// File: rtl/vga_fb_writer.sv
// vga_fb_writer: turns pixel/fill commands into clipped row-major video RAM byte writes
module vga_fb_writer
  import vga_pkg::*;
#(
  parameter int HPOS_WIDTH = 10,
  parameter int VPOS_WIDTH = 10,
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [HPOS_WIDTH-1:0] cmd_x,
  input  logic [VPOS_WIDTH-1:0] cmd_y,
  input  logic [HPOS_WIDTH-1:0] cmd_w,
  input  logic [VPOS_WIDTH-1:0] cmd_h,
  input  rgb332_t               cmd_color,
  output logic                  fb_we,
  input  logic                  fb_wready,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output rgb332_t               fb_wdata,
  output logic                  busy,
  output logic                  clip_err
);
  localparam logic [HPOS_WIDTH:0] HMAX = (HPOS_WIDTH+1)'(H_DISPLAY);
  localparam logic [VPOS_WIDTH:0] VMAX = (VPOS_WIDTH+1)'(V_DISPLAY);
  fb_state_t state, state_n;
  logic [HPOS_WIDTH-1:0] x, w;
  logic [VPOS_WIDTH-1:0] y, h;
  rgb332_t color;
  logic [HPOS_WIDTH:0] x_sum, x_end;
  logic [VPOS_WIDTH:0] y_sum, y_end;
  logic accept, off, empty, last, done;
  assign cmd_ready = state == S_IDLE && !rst;
  assign accept = cmd_valid && cmd_ready;
  assign x_sum = {1'b0, x} + {1'b0, w};
  assign y_sum = {1'b0, y} + {1'b0, h};
  assign x_end = x_sum > HMAX ? HMAX : x_sum;
  assign y_end = y_sum > VMAX ? VMAX : y_sum;
  assign off = {1'b0, x} >= HMAX || {1'b0, y} >= VMAX;
  assign empty = off || w == '0 || h == '0;
  assign clip_err = state == S_SETUP && (off || (!empty && (x_sum > HMAX || y_sum > VMAX)));
  assign busy = state != S_IDLE;
  assign fb_we = state == S_WRITE;
  assign fb_wdata = color;
  assign done = fb_we && fb_wready && last;
  always_comb
    state_n = state == S_IDLE ? (accept ? S_SETUP : S_IDLE)
            : state == S_SETUP ? (empty ? S_IDLE : S_WRITE)
            : state == S_WRITE && !done ? S_WRITE : S_IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      x <= '0;
      y <= '0;
      w <= '0;
      h <= '0;
      color <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        x <= cmd_x;
        y <= cmd_y;
        w <= fb_op_t'(cmd_op) == FB_FILL ? cmd_w : HPOS_WIDTH'(1);
        h <= fb_op_t'(cmd_op) == FB_FILL ? cmd_h : VPOS_WIDTH'(1);
        color <= cmd_color;
      end
    end
  vga_fb_addr_gen #(
    .HW(HPOS_WIDTH),
    .VW(VPOS_WIDTH),
    .AW(ADDR_WIDTH),
    .H(H_DISPLAY)
  ) u_addr_gen (
    .clk(clk),
    .rst(rst),
    .load(state == S_SETUP && !empty),
    .step(fb_we && fb_wready && !last),
    .x_start(x),
    .y_start(y),
    .x_end(x_end),
    .y_end(y_end),
    .addr(fb_addr),
    .last(last)
  );
endmodule

// File: tb/tb_vga_fb_writer.sv
// tb_vga_fb_writer: directed checks of vga_fb_writer command-to-write conversion
module tb_vga_fb_writer;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_op = 0, fb_wready = 1;
  logic [9:0] cmd_x = 0, cmd_y = 0, cmd_w = 0, cmd_h = 0;
  logic [7:0] cmd_color = 0;
  logic cmd_ready, fb_we, busy, clip_err;
  logic [18:0] fb_addr;
  logic [7:0] fb_wdata;
  int total = 0, bad = 0, nclip = 0, nacc = 0;
  int wa[$], wd[$];
  int a, b, c;
  int e2[4] = '{638, 639, 1278, 1279};
  int a3[5] = '{0, 1, 1, 1, 2};
  logic rdy3[5] = '{1, 0, 0, 1, 1};
  always #5 clk = ~clk;
  vga_fb_writer dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_w(cmd_w),
    .cmd_h(cmd_h),
    .cmd_color(cmd_color),
    .fb_we(fb_we),
    .fb_wready(fb_wready),
    .fb_addr(fb_addr),
    .fb_wdata(fb_wdata),
    .busy(busy),
    .clip_err(clip_err)
  );
  always @(posedge clk) begin
    if (fb_we && fb_wready) begin
      wa.push_back(int'(fb_addr));
      wd.push_back(int'(fb_wdata));
    end
    if (clip_err) nclip++;
    if (cmd_valid && cmd_ready) nacc++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic op, input int x, input int y, input int w, input int h, input int col);
    cmd_op = op;
    cmd_x = 10'(x);
    cmd_y = 10'(y);
    cmd_w = 10'(w);
    cmd_h = 10'(h);
    cmd_color = 8'(col);
    cmd_valid = 1;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    chk("send_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
  endtask
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 50 && busy; i++) tick();
    chk(tag, busy, 0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_we", fb_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_clip", clip_err, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_wdata", fb_wdata, 0);
    rst = 0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);
    b = wa.size();
    c = nclip;
    send(0, 3, 2, 7, 7, 8'hE0);
    chk("t1_setup_we", fb_we, 0);
    tick();
    chk("t1_we", fb_we, 1);
    chk("t1_addr", fb_addr, 1283);
    chk("t1_data", fb_wdata, 8'hE0);
    tick();
    chk("t1_busy", busy, 0);
    chk("t1_ready", cmd_ready, 1);
    chk("t1_nw", wa.size() - b, 1);
    chk("t1_nclip", nclip - c, 0);
    b = wa.size();
    c = nclip;
    send(1, 638, 0, 4, 2, 8'h1C);
    chk("t2_clip_pulse", clip_err, 1);
    tick();
    chk("t2_clip_once", clip_err, 0);
    wait_idle("t2_idle");
    chk("t2_nw", wa.size() - b, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_addr", wa[b+k], e2[k]);
      chk("t2_data", wd[b+k], 8'h1C);
    end
    chk("t2_nclip", nclip - c, 1);
    b = wa.size();
    send(1, 0, 0, 3, 1, 8'h55);
    tick();
    for (int k = 0; k < 5; k++) begin
      fb_wready = rdy3[k];
      chk("t3_we", fb_we, 1);
      chk("t3_addr", fb_addr, a3[k]);
      tick();
    end
    fb_wready = 1;
    chk("t3_busy", busy, 0);
    chk("t3_nw", wa.size() - b, 3);
    b = wa.size();
    c = nclip;
    send(0, 640, 0, 0, 0, 8'hAA);
    chk("t4a_clip", clip_err, 1);
    chk("t4a_we", fb_we, 0);
    tick();
    chk("t4a_ready", cmd_ready, 1);
    send(1, 5, 5, 0, 3, 8'hBB);
    chk("t4b_clip", clip_err, 0);
    chk("t4b_we", fb_we, 0);
    tick();
    chk("t4b_ready", cmd_ready, 1);
    chk("t4_nw", wa.size() - b, 0);
    chk("t4_nclip", nclip - c, 1);
    b = wa.size();
    send(1, 0, 0, 640, 480, 8'h77);
    for (int i = 0; i < 1100 && wa.size() - b < 1000; i++) tick();
    chk("t5_nw", wa.size() - b, 1000);
    chk("t5_last_addr", wa[b+999], 999);
    chk("t5_addr", fb_addr, 1000);
    chk("t5_we", fb_we, 1);
    rst = 1;
    tick();
    chk("t5_rst_we", fb_we, 0);
    chk("t5_rst_busy", busy, 0);
    rst = 0;
    tick();
    chk("t5_ready", cmd_ready, 1);
    b = wa.size();
    a = nacc;
    cmd_op = 0;
    cmd_x = 10;
    cmd_y = 1;
    cmd_color = 8'h11;
    cmd_valid = 1;
    tick();
    cmd_x = 11;
    cmd_color = 8'h22;
    chk("t6_acc1", nacc - a, 1);
    tick();
    chk("t6_hold1", nacc - a, 1);
    tick();
    chk("t6_hold2", nacc - a, 1);
    chk("t6_ready", cmd_ready, 1);
    tick();
    chk("t6_acc2", nacc - a, 2);
    cmd_valid = 0;
    wait_idle("t6_idle");
    chk("t6_nacc", nacc - a, 2);
    chk("t6_nw", wa.size() - b, 2);
    chk("t6_addr0", wa[b], 650);
    chk("t6_data0", wd[b], 8'h11);
    chk("t6_addr1", wa[b+1], 651);
    chk("t6_data1", wd[b+1], 8'h22);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
